// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared definitions for the RV32M multiply/divide unit.
//   - Funct3 operation codes (MUL..REMU)
//   - FSM state enum
//   - iteration count for the shift-add / restoring-divide loop
//   - small two's-complement helper
package rv32m_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_COUNT = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] value);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/rv32m_iter_core.sv
// rv32m_iter_core: one iteration per cycle on a 64-bit working register.
//   Multiply: work = {acc_hi, multiplier}; shift-add of the operand (multiplicand).
//   Divide:   work = {remainder, dividend/quotient}; restoring step against the operand (divisor).
//   After 32 steps work holds the 64-bit product, or {remainder, quotient}.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_load              load i_init_work / i_operand
//   i_step              perform one iteration
//   i_is_div            select divide step instead of multiply step
//   i_init_work         initial working register value
//   i_operand           multiplicand or divisor magnitude
//   o_work              current working register
//   o_work_next         working register after the step taken this cycle
module rv32m_iter_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_is_div,
    input  logic [63:0] i_init_work,
    input  logic [31:0] i_operand,
    output logic [63:0] o_work,
    output logic [63:0] o_work_next
);

    logic [63:0] r_work;
    logic [31:0] r_operand;

    logic [32:0] w_add;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_shift;
    logic        w_fits;
    logic [31:0] w_rem_sub;
    logic [63:0] w_div_next;

    always_comb begin
        // Shift-add: add multiplicand into the high half when the multiplier LSB is set,
        // then shift the whole register right by one (carry enters bit 63).
        w_add      = {1'b0, r_work[63:32]} + {1'b0, r_operand};
        w_mul_next = r_work[0] ? {w_add, r_work[31:1]}
                               : {1'b0, r_work[63:32], r_work[31:1]};

        // Restoring divide: bring the next dividend bit into the partial remainder and
        // subtract the divisor only if it fits.
        w_rem_shift = {r_work[63:32], r_work[31]};
        w_fits      = (w_rem_shift >= {1'b0, r_operand});
        w_rem_sub   = 32'(w_rem_shift - {1'b0, r_operand});
        w_div_next  = w_fits ? {w_rem_sub, r_work[30:0], 1'b1}
                             : {w_rem_shift[31:0], r_work[30:0], 1'b0};

        o_work_next = i_is_div ? w_div_next : w_mul_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work    <= '0;
            r_operand <= '0;
        end else if (i_load) begin
            r_work    <= i_init_work;
            r_operand <= i_operand;
        end else if (i_step) begin
            r_work    <= o_work_next;
        end
    end

    assign o_work = r_work;

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Takes 32 RUN cycles on magnitudes with a final sign fix-up; divide-by-zero and the
// signed overflow case finish without RUN. Drives the register-file write port for
// the single DONE cycle and never writes x0.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   Start           level request, held for the whole instruction
//   Funct3          operation select
//   OperandA/B      rs1 / rs2 values
//   DestReg         rd index
//   Stall           combinational PC hold
//   RegWrite        write enable (registered, high only in DONE)
//   WriteRegNum     rd (registered)
//   WriteRegData    result (registered)
module rv32m_muldiv_unit
    import rv32m_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [2:0]  Funct3,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic [4:0]  DestReg,
    output logic        Stall,
    output logic        RegWrite,
    output logic [4:0]  WriteRegNum,
    output logic [31:0] WriteRegData
);

    localparam logic [5:0] ITER_LAST = 6'(ITER_COUNT - 1);

    state_e      r_state;
    logic [5:0]  r_iter_cnt;
    logic [2:0]  r_funct3;
    logic [4:0]  r_dest;
    logic        r_neg_res;
    logic        r_reg_write;
    logic [4:0]  r_wr_num;
    logic [31:0] r_wr_data;

    logic        w_sign_a;
    logic        w_sign_b;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_neg_res;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic [31:0] w_special_result;
    logic        w_core_load;
    logic        w_core_step;
    logic        w_core_is_div;
    logic [63:0] w_work;
    logic [63:0] w_work_next;
    logic [63:0] w_prod;
    logic [31:0] w_result;

    // Operand decode at issue time.
    always_comb begin
        w_sign_a = (Funct3 == F3_MULH) | (Funct3 == F3_MULHSU) |
                   (Funct3 == F3_DIV)  | (Funct3 == F3_REM);
        w_sign_b = (Funct3 == F3_MULH) | (Funct3 == F3_DIV) | (Funct3 == F3_REM);
        w_neg_a  = w_sign_a & OperandA[31];
        w_neg_b  = w_sign_b & OperandB[31];
        w_mag_a  = negate_if(w_neg_a, OperandA);
        w_mag_b  = negate_if(w_neg_b, OperandB);

        // Remainder follows the dividend; product and quotient follow the sign XOR.
        w_neg_res = (Funct3 == F3_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);

        w_div_zero = Funct3[2] & (OperandB == 32'd0);
        w_div_ovf  = ((Funct3 == F3_DIV) | (Funct3 == F3_REM)) &
                     (OperandA == 32'h8000_0000) & (OperandB == 32'hFFFF_FFFF);
        w_special  = w_div_zero | w_div_ovf;

        if (w_div_zero) begin
            w_special_result = Funct3[1] ? OperandA : 32'hFFFF_FFFF;
        end else begin
            w_special_result = Funct3[1] ? 32'd0 : 32'h8000_0000;
        end

        w_core_load = (r_state == IDLE) & Start & ~w_special;
        w_core_step = (r_state == RUN);
        // At load the step result is discarded, so only the RUN value of this matters.
        w_core_is_div = r_funct3[2];
    end

    rv32m_iter_core u_iter_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_core_load),
        .i_step      (w_core_step),
        .i_is_div    (w_core_is_div),
        .i_init_work ({32'd0, w_mag_a}),
        .i_operand   (w_mag_b),
        .o_work      (w_work),
        .o_work_next (w_work_next)
    );

    // Final result from the last iteration's output, with sign fix-up.
    always_comb begin
        w_prod = r_neg_res ? (~w_work_next + 64'd1) : w_work_next;
        case (r_funct3)
            F3_MUL:                      w_result = w_prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_result = w_prod[63:32];
            F3_DIV, F3_DIVU:             w_result = negate_if(r_neg_res, w_work_next[31:0]);
            default:                     w_result = negate_if(r_neg_res, w_work_next[63:32]);
        endcase
    end

    // FSM with registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_iter_cnt  <= '0;
            r_funct3    <= '0;
            r_dest      <= '0;
            r_neg_res   <= 1'b0;
            r_reg_write <= 1'b0;
            r_wr_num    <= '0;
            r_wr_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_reg_write <= 1'b0;
                    if (Start) begin
                        r_funct3   <= Funct3;
                        r_dest     <= DestReg;
                        r_neg_res  <= w_neg_res;
                        r_iter_cnt <= '0;
                        if (w_special) begin
                            r_state     <= DONE;
                            r_reg_write <= (DestReg != 5'd0);
                            r_wr_num    <= DestReg;
                            r_wr_data   <= w_special_result;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_iter_cnt <= r_iter_cnt + 6'd1;
                    if (r_iter_cnt == ITER_LAST) begin
                        r_state     <= DONE;
                        r_reg_write <= (r_dest != 5'd0);
                        r_wr_num    <= r_dest;
                        r_wr_data   <= w_result;
                    end
                end
                DONE: begin
                    // Start is still the same instruction here; do not re-issue.
                    r_reg_write <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_reg_write <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Stall = ((r_state == IDLE) & Start) | (r_state == RUN);
    end

    assign RegWrite     = r_reg_write;
    assign WriteRegNum  = r_wr_num;
    assign WriteRegData = r_wr_data;

    // Only the next-state value of the working register is consumed here.
    logic w_unused;
    assign w_unused = ^w_work;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
module tb_rv32m_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [4:0]  DestReg;
    logic        Stall;
    logic        RegWrite;
    logic [4:0]  WriteRegNum;
    logic [31:0] WriteRegData;

    int errors = 0;
    int checks = 0;

    rv32m_muldiv_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Start        (Start),
        .Funct3       (Funct3),
        .OperandA     (OperandA),
        .OperandB     (OperandB),
        .DestReg      (DestReg),
        .Stall        (Stall),
        .RegWrite     (RegWrite),
        .WriteRegNum  (WriteRegNum),
        .WriteRegData (WriteRegData)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the RISC-V definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        p  = '0;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(int'(a) / int'(b));
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(int'(a) % int'(b));
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Issue one instruction, hold Start until DONE, check timing and the write.
    // Returns at E(last)+1 with Start low, so a caller may issue again immediately.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string name);
        logic [31:0] exp_data;
        int          exp_n;
        int          n;
        bit          done;
        bit          early_wr;
        exp_data = ref_result(f3, a, b);
        exp_n    = is_special(f3, a, b) ? 1 : 33;
        Funct3   = f3;
        OperandA = a;
        OperandB = b;
        DestReg  = rd;
        Start    = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b1) begin
            errors++;
            $display("FAIL %s stall_at_start: got %b expected 1", name, Stall);
        end
        n        = 0;
        done     = 0;
        early_wr = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (Stall === 1'b0) done = 1;
            else if (RegWrite !== 1'b0) early_wr = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got no DONE within %0d cycles expected %0d", name, n,
                     exp_n);
        end else begin
            if (n !== exp_n) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, n, exp_n);
            end
            checks++;
            if (early_wr) begin
                errors++;
                $display("FAIL %s early_write: got RegWrite=1 expected 0 before DONE", name);
            end
            checks++;
            if (RegWrite !== (rd != 5'd0)) begin
                errors++;
                $display("FAIL %s regwrite: got %b expected %b", name, RegWrite, rd != 5'd0);
            end
            if (rd != 5'd0) begin
                checks++;
                if (WriteRegNum !== rd) begin
                    errors++;
                    $display("FAIL %s regnum: got %0d expected %0d", name, WriteRegNum, rd);
                end
                checks++;
                if (WriteRegData !== exp_data) begin
                    errors++;
                    $display("FAIL %s data: got %h expected %h (f3=%0d a=%h b=%h)", name,
                             WriteRegData, exp_data, f3, a, b);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL %s regwrite_after_done: got %b expected 0", name, RegWrite);
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        Start    = 1'b0;
        Funct3   = '0;
        OperandA = '0;
        OperandB = '0;
        DestReg  = '0;
        #12;
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++; $display("FAIL reset regwrite: got %b expected 0", RegWrite);
        end
        checks++;
        if (WriteRegNum !== 5'd0) begin
            errors++; $display("FAIL reset regnum: got %0d expected 0", WriteRegNum);
        end
        checks++;
        if (WriteRegData !== 32'd0) begin
            errors++; $display("FAIL reset data: got %h expected 0", WriteRegData);
        end
        checks++;
        if (Stall !== 1'b0) begin
            errors++; $display("FAIL reset stall_idle: got %b expected 0", Stall);
        end
        Start = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b1) begin
            errors++; $display("FAIL reset stall_follows_start: got %b expected 1", Stall);
        end
        Start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, "mul_7x-3");
    endtask

    task automatic test_mul_high();
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, "mulhu_ff");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, "mulh_ff");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, "mulhsu_ff");
    endtask

    task automatic test_div_signed();
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, "div_-7/2");
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd10, "divu_fff9/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, "rem_-7/2");
    endtask

    task automatic test_special();
        run_op(3'd4, 32'd5, 32'd0, 5'd12, "div_by_zero");
        run_op(3'd7, 32'd5, 32'd0, 5'd13, "remu_by_zero");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, "div_overflow");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, "rem_overflow");
    endtask

    task automatic test_rd_zero();
        run_op(3'd0, 32'd3, 32'd4, 5'd0, "mul_rd0");
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, "b2b_mul");
        run_op(3'd5, 32'hDEAD_BEEF, 32'h0000_1234, 5'd21, "b2b_divu");
        run_op(3'd6, 32'h8765_4321, 32'hFFFF_FF00, 5'd22, "b2b_rem");
    endtask

    task automatic test_reset_abort();
        bit wrote;
        bit stalled;
        Funct3   = 3'd0;
        OperandA = 32'h0000_0123;
        OperandB = 32'h0000_0456;
        DestReg  = 5'd9;
        Start    = 1'b1;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        Start = 1'b0;
        #1;
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++; $display("FAIL abort regwrite: got %b expected 0", RegWrite);
        end
        checks++;
        if (WriteRegNum !== 5'd0) begin
            errors++; $display("FAIL abort regnum: got %0d expected 0", WriteRegNum);
        end
        checks++;
        if (WriteRegData !== 32'd0) begin
            errors++; $display("FAIL abort data: got %h expected 0", WriteRegData);
        end
        #1;
        rst_n   = 1'b1;
        wrote   = 0;
        stalled = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (RegWrite !== 1'b0) wrote = 1;
            if (Stall !== 1'b0) stalled = 1;
        end
        checks++;
        if (wrote) begin
            errors++; $display("FAIL abort no_write: got RegWrite=1 expected 0");
        end
        checks++;
        if (stalled) begin
            errors++; $display("FAIL abort idle: got Stall=1 expected 0 with Start low");
        end
        run_op(3'd5, 32'd100, 32'd7, 5'd12, "divu_after_reset");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($signed(8'($urandom))); b = 32'($signed(4'($urandom))); end
                default: ;
            endcase
            run_op(f3, a, b, rd, "random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_high();
        test_div_signed();
        test_special();
        test_rd_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
